// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 4x4 multiplier controller.
//   - Operand and product widths
//   - FSM state type
//   - Per-step digit selection and partial-product shift amount
package mult_pkg;

  localparam int unsigned OPW   = 4;
  localparam int unsigned PRODW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Left shift applied to the partial product of step k: {0,2,2,4}
  function automatic logic [2:0] sh(input logic [1:0] k);
    case (k)
      2'd0:       sh = 3'd0;
      2'd1, 2'd2: sh = 3'd2;
      default:    sh = 3'd4;
    endcase
  endfunction

  // Digit of a used in step k: low digit on even steps, high digit on odd steps
  function automatic logic [1:0] digit_a(input logic [OPW-1:0] x, input logic [1:0] k);
    return k[0] ? x[3:2] : x[1:0];
  endfunction

  // Digit of b used in step k: low digit for steps 0/1, high digit for steps 2/3
  function automatic logic [1:0] digit_b(input logic [OPW-1:0] x, input logic [1:0] k);
    return k[1] ? x[3:2] : x[1:0];
  endfunction

endpackage

// File: rtl/mult_pp_accum.sv
// Partial-product accumulator for mult4x4_seq.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clear      clear accumulator (new operation accepted)
//   i_add_en     add the shifted partial product this cycle
//   i_step       current step 0..3, selects the shift amount
//   i_pp         4-bit partial product from the 2-bit multiplier
//   o_sum        accumulator plus shifted partial product (combinational)
module mult_pp_accum
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_add_en,
  input  logic [1:0]       i_step,
  input  logic [3:0]       i_pp,
  output logic [PRODW-1:0] o_sum
);

  logic [PRODW-1:0] r_acc;
  logic [PRODW-1:0] w_addend;

  // Max running sum is 225, so 8 bits never overflow
  assign w_addend = {{(PRODW-4){1'b0}}, i_pp} << sh(i_step);
  assign o_sum    = r_acc + w_addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_add_en) begin
      r_acc <= o_sum;
    end
  end

endmodule

// File: rtl/mult4x4_seq.sv
// Sequential 4x4 unsigned multiplier controller driving an external 2-bit
// multiplier cell. Operands are split into 2-bit digits, one digit pair per
// step; partial products are shifted and accumulated into an 8-bit product.
// Parameters:
//   SETTLE  extra hold cycles per step before sampling pp_res (0..7)
// Configuration macro:
//   ZERO_SKIP_EN  when defined, a zero operand completes in one cycle
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, accepted in IDLE or DONE
//   a, b            operands, captured on accepted start
//   pp_a, pp_b      registered digits driven to the 2-bit multiplier
//   pp_res          combinational 2-bit multiplier result
//   busy            high while a multiplication runs
//   done            one-cycle completion pulse
//   product         a*b, held until the next completion or reset
module mult4x4_seq
  import mult_pkg::*;
#(
  parameter int unsigned SETTLE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [1:0]       pp_a,
  output logic [1:0]       pp_b,
  input  logic [3:0]       pp_res,
  output logic             busy,
  output logic             done,
  output logic [PRODW-1:0] product
);

  localparam logic [2:0] LP_SETTLE = 3'(SETTLE);

  state_t           r_state;
  logic [OPW-1:0]   r_ra;
  logic [OPW-1:0]   r_rb;
  logic [1:0]       r_step;
  logic [2:0]       r_wait;
  logic [1:0]       r_pp_a;
  logic [1:0]       r_pp_b;
  logic             r_busy;
  logic             r_done;
  logic [PRODW-1:0] r_product;

  logic             w_accept;
  logic             w_step_end;
  logic             w_zero;
  logic [PRODW-1:0] w_sum;

  assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;
  assign w_step_end = (r_state == S_RUN) && (r_wait == LP_SETTLE);

`ifdef ZERO_SKIP_EN
  assign w_zero = (a == '0) || (b == '0);
`else
  assign w_zero = 1'b0;
`endif

  mult_pp_accum u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_accept),
    .i_add_en (w_step_end),
    .i_step   (r_step),
    .i_pp     (pp_res),
    .o_sum    (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ra      <= '0;
      r_rb      <= '0;
      r_step    <= '0;
      r_wait    <= '0;
      r_pp_a    <= '0;
      r_pp_b    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        // DONE accepts start exactly like IDLE, allowing back-to-back use
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_pp_a  <= '0;
          r_pp_b  <= '0;
          if (start) begin
            r_ra   <= a;
            r_rb   <= b;
            r_step <= '0;
            r_wait <= '0;
            if (w_zero) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_product <= '0;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_pp_a  <= a[1:0];
              r_pp_b  <= b[1:0];
            end
          end
        end

        S_RUN: begin
          if (r_wait == LP_SETTLE) begin
            r_wait <= '0;
            if (r_step == 2'd3) begin
              r_product <= w_sum;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_pp_a    <= '0;
              r_pp_b    <= '0;
              r_step    <= '0;
              r_state   <= S_DONE;
            end else begin
              r_step <= r_step + 2'd1;
              r_pp_a <= digit_a(r_ra, r_step + 2'd1);
              r_pp_b <= digit_b(r_rb, r_step + 2'd1);
            end
          end else begin
            r_wait <= r_wait + 3'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pp_a  <= '0;
          r_pp_b  <= '0;
        end
      endcase
    end
  end

  assign pp_a    = r_pp_a;
  assign pp_b    = r_pp_b;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: doc/mult4x4_seq.md
Name: mult4x4_seq

Overview:
- Sequential 4x4 unsigned multiplier controller that sits directly upstream and downstream of the existing 2-bit multiplier cell array.
- It slices the two 4-bit operands into 2-bit digits and drives them, one pair per step, into the 2-bit multiplier.
- It consumes the 4-bit partial products, shifts them and accumulates an 8-bit product, with a start/busy/done handshake toward the system.

Parameters:
- SETTLE, 0: extra hold cycles per step before the partial product is sampled (0..7); covers slow cell chains in the 2-bit multiplier.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset.
- start  in  1  request; sampled when accepting (IDLE or DONE).
- a  in  4  multiplicand, captured on accepted start.
- b  in  4  multiplier, captured on accepted start.
- pp_a  out  2  digit of a driven to the 2-bit multiplier (registered).
- pp_b  out  2  digit of b driven to the 2-bit multiplier (registered).
- pp_res  in  4  combinational result from the 2-bit multiplier for the current pp_a, pp_b.
- busy  out  1  high while a multiplication is in progress.
- done  out  1  one-cycle pulse; product valid.
- product  out  8  a*b, held until the next accepted start.

Interface rule: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, any time including mid-operation):
  - state IDLE.
  - busy=0, done=0, product=0, pp_a=0, pp_b=0, step=0, wait counter=0.
  - Any partial result is discarded.
- FSM states: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On start=1, capture a and b into ra and rb, clear the accumulator.
  - Drive pp_a=ra[1:0], pp_b=rb[1:0], set busy=1, go to RUN with step=0.
- RUN, per step k (0..3):
  - pp_a and pp_b are held for 1+SETTLE cycles.
  - On the last cycle of the step, acc <= acc + (pp_res << sh(k)).
  - Then advance pp_a and pp_b to the next digit pair.
  - Digit pairs and shifts:
    - k0: a[1:0] x b[1:0], shift 0.
    - k1: a[3:2] x b[1:0], shift 2.
    - k2: a[1:0] x b[3:2], shift 2.
    - k3: a[3:2] x b[3:2], shift 4.
  - After k3 accumulates: product <= final sum, done=1, busy=0, go to DONE.
- DONE (exactly one cycle):
  - done=1.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: accepted start at edge N gives done=1 in the cycle after edge N+4*(1+SETTLE). With SETTLE=0: 4 busy cycles, then the done cycle.
- start while busy is ignored; a and b are don't-care after capture.
- Width: acc is 8 bits unsigned. Max 15*15=225 and no intermediate sum exceeds 225, so no overflow or carry-out logic.
- product changes only at completion or reset, never during RUN.
- pp_a and pp_b return to 0 in IDLE/DONE (low toggle activity into the cell array).

Optional Feature:
- ZERO_SKIP_EN defined:
  - At an accepted start with a==0 or b==0, skip RUN entirely: next cycle is DONE with product=0, busy stays 0.
  - Latency is 1 cycle.
  - pp_a and pp_b never leave 0.
- ZERO_SKIP_EN undefined: all operands take the full 4*(1+SETTLE) sequence.

Decomposition:
- Shared package mult_pkg holds:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - OPW=4 and PRODW=8.
  - the per-step shift table sh(k) = {0,2,2,4}.
- One sub-module is natural: mult_pp_accum (8-bit accumulator with clear, shift-by-sh(k) and add-enable).
- FSM, step counter and settle counter stay in mult4x4_seq.
- A top-level wrapper connects pp_a, pp_b and pp_res to the existing 2-bit multiplier.

Test Plan:
- Reset mid-operation: pulse rst_n low during step 2 of 13*11 -> all outputs 0 immediately; no done pulse; a following start with 13*11 yields product=143.
- Exhaustive, SETTLE=0: all 256 a,b pairs -> product==a*b; done exactly 5 cycles after start; busy high for 4 cycles; pp_a/pp_b sequence matches the k0..k3 table.
- Corner values: 15*15 -> 225 (8'hE1); 0*9 -> 0; 1*1 -> 1; 8*8 -> 64.
- Back-to-back: start held high through DONE with 7*6 then 5*3 -> two done pulses with 42 then 15; zero idle cycles between operations.
- Start while busy: start pulses during RUN with changed a,b are ignored; first operation 9*12 completes with 108; product held until next accept.
- SETTLE=2 and ZERO_SKIP_EN:
  - SETTLE=2: 10*10 -> done 13 cycles after start, product=100.
  - With ZERO_SKIP_EN, 0*14 -> done next cycle, product=0, pp_a/pp_b stay 0.
